sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single external async SRAM (19-bit address, 8-bit data) between two requesters.
- Port 0 is the CPU-side bus bridge and has priority. Port 1 is the secondary master (flash boot loader / DMA).
- Sequences the SramAdr/RamCEn/RamOEn/RamWEn/data strobes with fixed, parameterised timing.
- Sits between the CPU bus-decode logic and the top-level SRAM pins, replacing direct SRAM pin control.

Parameters:
ACCESS_CYCLES, 2, clocks the strobe (OE or WE) is held active; legal 1..15
MAX_STREAK, 4, consecutive port-0 grants allowed while port 1 waits; 0 = strict priority (port 1 can starve)

Ports:
CLK  in  1  system clock; every output is registered on its rising edge
RESET  in  1  synchronous, active-high reset
p0_req / p1_req  in  1  request; held high until the matching ack
p0_we / p1_we  in  1  1 = write, 0 = read; sampled at grant
p0_addr / p1_addr  in  19  SRAM byte address; sampled at grant
p0_wdata / p1_wdata  in  8  write data; sampled at grant
p0_ack / p1_ack  out  1  one-cycle completion pulse
p0_rdata / p1_rdata  out  8  read data; valid in the ack cycle, held until that port's next read completes
SramAdr  out  19  SRAM address
RamCEn / RamOEn / RamWEn  out  1  active-low SRAM strobes
sram_dq_o  out  8  data driven toward SRAM
sram_dq_oe  out  1  1 = top level drives SramDB from sram_dq_o
sram_dq_i  in  8  SramDB read-back
busy  out  1  high in every state except IDLE
owner  out  1  port currently or last granted

Behaviour:
- Reset values: all strobes 1, sram_dq_oe 0, SramAdr 0, sram_dq_o 0, acks 0, rdata 0, busy 0, owner 0, streak counter 0, state IDLE.
- States are IDLE, SETUP, ACCESS, HOLD, DONE.
- IDLE: the arbiter evaluates p0_req and p1_req.
  - Winner's we/addr/wdata are latched; owner is updated; next state is SETUP.
  - No request: stay in IDLE.
- SETUP (1 cycle): SramAdr = latched address, RamCEn = 0.
  - Read: RamOEn = 0.
  - Write: sram_dq_oe = 1 and sram_dq_o = wdata. RamWEn stays 1 (address setup).
- ACCESS (ACCESS_CYCLES cycles, counted by a 4-bit down-counter): strobes as in SETUP, plus RamWEn = 0 for a write.
  - Read: sram_dq_i is captured into the owner's rdata at the end of the last ACCESS cycle.
- HOLD (writes only, 1 cycle): RamWEn = 1. CE, address and data are still driven (data hold).
- DONE (1 cycle): all strobes 1, sram_dq_oe 0, owner's ack = 1. Next state is IDLE. The address bus holds its last value.
- Latency from the IDLE cycle that sees req to the ack cycle:
  - Read: ACCESS_CYCLES + 2 (4 at default).
  - Write: ACCESS_CYCLES + 3 (5 at default).
  - Re-arbitration happens in the IDLE cycle after DONE.
- Arbitration when both ports request:
  - Port 0 wins unless MAX_STREAK != 0 and streak == MAX_STREAK, in which case port 1 wins.
  - Streak increments on a port-0 grant while p1_req = 1.
  - Streak clears on a port-1 grant, and on a port-0 grant while p1_req = 0.
  - Streak saturates at MAX_STREAK.
- Only one port is granted per transaction. The other port's ack never pulses while it is not the owner.
- Deasserting req before ack is a protocol error. The transaction still completes using the latched values, and the ack still pulses.
- Changing addr, we or wdata after grant has no effect.
- RESET asserted in any state: next cycle all outputs return to reset values.
  - The in-flight transaction is abandoned with no ack; the requester must re-issue.
  - The WE strobe terminates within one clock.
- sram_dq_oe and RamOEn = 0 are never active in the same cycle (no bus contention). This is a bench assertion.
- Invalid state encodings recover to IDLE with strobes inactive.

Decomposition:
- Package sram_arb_pkg:
  - state enum (IDLE, SETUP, ACCESS, HOLD, DONE)
  - SRAM_AW = 19, SRAM_DW = 8
  - port-ID constants PORT_CPU = 0, PORT_AUX = 1
- One sub-module, sram_arb_pick: combinational winner selection plus the registered streak counter.
- The FSM, the timing counter and the pin registers stay in sram_arbiter.

Test Plan:
1. Read, defaults: preload SRAM model 0x1234A = 0x5A; p0 read 0x1234A → RamOEn low for 3 cycles, p0_ack 4 cycles after req, p0_rdata = 0x5A.
2. Write: p1 write 0x7FFFF = 0xC3 → RamWEn low exactly 2 cycles, bracketed by 1 cycle of CE/data setup and 1 of hold; p1_ack at cycle 5; model holds 0xC3.
3. Simultaneous requests, both raised in the same cycle → p0 served first, then p1; no overlapping acks; owner toggles 0 then 1.
4. Starvation, MAX_STREAK = 4: p0 continuously requesting, p1 held high → grant order 0,0,0,0,1,0,0,0,0,1.
5. Strict priority, MAX_STREAK = 0: same stimulus as test 4 → p1 never granted over 20 transactions; p1 is granted in the first IDLE cycle after p0_req drops.
6. Reset mid-write: RESET asserted during the first ACCESS cycle → next cycle RamWEn/RamCEn = 1, sram_dq_oe = 0, no ack; a re-issued request completes normally. ACCESS_CYCLES = 1 and 15 regression runs pass tests 1–2.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM arbiter
package sram_arb_pkg;

  localparam int SRAM_AW = 19;
  localparam int SRAM_DW = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - winner selection with a bounded port-0 streak
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic p0_req,
  input  logic p1_req,
  output logic grant_valid,
  output logic grant_port
);

  localparam logic [7:0] STREAK_MAX = 8'(MAX_STREAK);

  logic [7:0] streak;
  logic       force_aux;

  always_comb begin
    force_aux   = (MAX_STREAK != 0) && (streak == STREAK_MAX);
    grant_valid = arb_en && (p0_req || p1_req);
    grant_port  = (!p0_req || (p1_req && force_aux)) ? PORT_AUX : PORT_CPU;
  end

  // Streak only counts CPU wins that actually made the aux port wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (grant_valid) begin
      if (grant_port == PORT_AUX) begin
        streak <= '0;
      end else if (p1_req) begin
        if (streak != STREAK_MAX) begin
          streak <= streak + 8'd1;
        end
      end else begin
        streak <= '0;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter and strobe sequencer for the external async SRAM
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_STREAK    = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               p0_req,
  input  logic               p0_we,
  input  logic [SRAM_AW-1:0] p0_addr,
  input  logic [SRAM_DW-1:0] p0_wdata,
  output logic               p0_ack,
  output logic [SRAM_DW-1:0] p0_rdata,
  input  logic               p1_req,
  input  logic               p1_we,
  input  logic [SRAM_AW-1:0] p1_addr,
  input  logic [SRAM_DW-1:0] p1_wdata,
  output logic               p1_ack,
  output logic [SRAM_DW-1:0] p1_rdata,
  output logic [SRAM_AW-1:0] SramAdr,
  output logic               RamCEn,
  output logic               RamOEn,
  output logic               RamWEn,
  output logic [SRAM_DW-1:0] sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               busy,
  output logic               owner
);

  arb_state_t state, state_d;
  logic [3:0] cnt;

  logic               lat_we;
  logic [SRAM_AW-1:0] lat_addr;
  logic [SRAM_DW-1:0] lat_wdata;

  logic grant_valid, grant_port;

  logic               sel_we, cur_we;
  logic [SRAM_AW-1:0] sel_addr, cur_addr;
  logic [SRAM_DW-1:0] sel_wdata, cur_wdata;

  logic [SRAM_AW-1:0] adr_d;
  logic [SRAM_DW-1:0] dq_o_d;
  logic ce_d, oe_d, we_d, dq_oe_d, ack0_d, ack1_d, busy_d, capture;

  sram_arb_pick #(.MAX_STREAK(MAX_STREAK)) u_pick (
    .clk         (CLK),
    .reset       (RESET),
    .arb_en      (state == IDLE),
    .p0_req      (p0_req),
    .p1_req      (p1_req),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  always_comb begin
    sel_we    = (grant_port == PORT_AUX) ? p1_we    : p0_we;
    sel_addr  = (grant_port == PORT_AUX) ? p1_addr  : p0_addr;
    sel_wdata = (grant_port == PORT_AUX) ? p1_wdata : p0_wdata;
    // Pins are registered from the next state, so the grant cycle must see
    // the winner's inputs before they land in the latches.
    cur_we    = (state == IDLE) ? sel_we    : lat_we;
    cur_addr  = (state == IDLE) ? sel_addr  : lat_addr;
    cur_wdata = (state == IDLE) ? sel_wdata : lat_wdata;
  end

  always_comb begin
    state_d = IDLE;
    case (state)
      IDLE:    state_d = grant_valid ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = (cnt == 4'd1) ? (lat_we ? HOLD : DONE) : ACCESS;
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    adr_d   = SramAdr;
    dq_o_d  = sram_dq_o;
    ce_d    = 1'b1;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    dq_oe_d = 1'b0;
    case (state_d)
      SETUP, ACCESS: begin
        adr_d = cur_addr;
        ce_d  = 1'b0;
        if (cur_we) begin
          dq_oe_d = 1'b1;
          dq_o_d  = cur_wdata;
          we_d    = (state_d != ACCESS);
        end else begin
          oe_d = 1'b0;
        end
      end
      HOLD: begin
        adr_d   = cur_addr;
        ce_d    = 1'b0;
        dq_oe_d = 1'b1;
        dq_o_d  = cur_wdata;
      end
      default: ;
    endcase
    ack0_d  = (state_d == DONE) && (owner == PORT_CPU);
    ack1_d  = (state_d == DONE) && (owner == PORT_AUX);
    busy_d  = (state_d != IDLE);
    capture = (state == ACCESS) && (cnt == 4'd1) && !lat_we;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      owner      <= PORT_CPU;
      SramAdr    <= '0;
      sram_dq_o  <= '0;
      RamCEn     <= 1'b1;
      RamOEn     <= 1'b1;
      RamWEn     <= 1'b1;
      sram_dq_oe <= 1'b0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      busy       <= 1'b0;
    end else begin
      state <= state_d;
      if (state == SETUP) begin
        cnt <= 4'(ACCESS_CYCLES);
      end else if (state == ACCESS) begin
        cnt <= cnt - 4'd1;
      end
      if (grant_valid) begin
        lat_we    <= sel_we;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
        owner     <= grant_port;
      end
      SramAdr    <= adr_d;
      sram_dq_o  <= dq_o_d;
      RamCEn     <= ce_d;
      RamOEn     <= oe_d;
      RamWEn     <= we_d;
      sram_dq_oe <= dq_oe_d;
      p0_ack     <= ack0_d;
      p1_ack     <= ack1_d;
      busy       <= busy_d;
      if (capture) begin
        if (owner == PORT_CPU) begin
          p0_rdata <= sram_dq_i;
        end else begin
          p1_rdata <= sram_dq_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed bench over four arbiter configurations
module tb_sram_arbiter;

  localparam int N = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [N-1:0] rst, p0_req, p1_req, p0_we, p1_we, p0_ack, p1_ack;
  logic [N-1:0] ce, oe, we_n, dq_oe, busy, owner;
  logic [N-1:0][18:0] p0_addr, p1_addr, adr;
  logic [N-1:0][7:0]  p0_wdata, p1_wdata, p0_rdata, p1_rdata, dq_o, dq_i;

  // 0: defaults, 1: strict priority, 2: ACCESS_CYCLES=1, 3: ACCESS_CYCLES=15
  for (genvar g = 0; g < N; g++) begin : gen_dut
    sram_arbiter #(
      .ACCESS_CYCLES (g == 2 ? 1 : (g == 3 ? 15 : 2)),
      .MAX_STREAK    (g == 1 ? 0 : 4)
    ) u_dut (
      .CLK        (CLK),
      .RESET      (rst[g]),
      .p0_req     (p0_req[g]),
      .p0_we      (p0_we[g]),
      .p0_addr    (p0_addr[g]),
      .p0_wdata   (p0_wdata[g]),
      .p0_ack     (p0_ack[g]),
      .p0_rdata   (p0_rdata[g]),
      .p1_req     (p1_req[g]),
      .p1_we      (p1_we[g]),
      .p1_addr    (p1_addr[g]),
      .p1_wdata   (p1_wdata[g]),
      .p1_ack     (p1_ack[g]),
      .p1_rdata   (p1_rdata[g]),
      .SramAdr    (adr[g]),
      .RamCEn     (ce[g]),
      .RamOEn     (oe[g]),
      .RamWEn     (we_n[g]),
      .sram_dq_o  (dq_o[g]),
      .sram_dq_oe (dq_oe[g]),
      .sram_dq_i  (dq_i[g]),
      .busy       (busy[g]),
      .owner      (owner[g])
    );
  end

  logic [7:0] mem [int];
  logic       pre_go = 1'b0;
  int         pre_key;
  logic [7:0] pre_val;
  int         contention = 0;
  int         bad_ack = 0;

  function automatic int mkey(input int g, input logic [18:0] a);
    return g * 524288 + int'(a);
  endfunction

  function automatic logic [7:0] peek(input int k);
    return mem.exists(k) ? mem[k] : 8'h00;
  endfunction

  always @(posedge CLK) begin
    if (pre_go) mem[pre_key] = pre_val;
    for (int g = 0; g < N; g++)
      if (!ce[g] && !we_n[g]) mem[mkey(g, adr[g])] = dq_o[g];
  end

  always @(negedge CLK) begin
    for (int g = 0; g < N; g++) begin
      dq_i[g] <= (!ce[g] && !oe[g]) ? peek(mkey(g, adr[g])) : 8'hEE;
      if (dq_oe[g] && !oe[g]) contention <= contention + 1;
      if ((p0_ack[g] && owner[g] != 1'b0) || (p1_ack[g] && owner[g] != 1'b1) ||
          (p0_ack[g] && p1_ack[g]))
        bad_ack <= bad_ack + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input int g, input logic [18:0] a, input logic [7:0] v);
    pre_key = mkey(g, a);
    pre_val = v;
    pre_go  = 1'b1;
    step();
    pre_go  = 1'b0;
  endtask

  int t_lat, t_oe, t_we, t_dqoe, t_ce_first, t_ce_last, t_we_first, t_we_last;
  logic [7:0] t_rd;
  logic t_own;

  task automatic txn(input int g, input int port, input logic w,
                     input logic [18:0] a, input logic [7:0] d);
    logic ack;
    step();
    if (port == 0) begin
      p0_we[g] = w; p0_addr[g] = a; p0_wdata[g] = d; p0_req[g] = 1'b1;
    end else begin
      p1_we[g] = w; p1_addr[g] = a; p1_wdata[g] = d; p1_req[g] = 1'b1;
    end
    t_lat = -1; t_oe = 0; t_we = 0; t_dqoe = 0;
    t_ce_first = -1; t_ce_last = -1; t_we_first = -1; t_we_last = -1;
    t_rd = 8'h00; t_own = 1'b0;
    for (int c = 1; c <= 40 && t_lat < 0; c++) begin
      step();
      if (!ce[g]) begin
        if (t_ce_first < 0) t_ce_first = c;
        t_ce_last = c;
      end
      if (!oe[g]) t_oe++;
      if (dq_oe[g]) t_dqoe++;
      if (!we_n[g]) begin
        if (t_we_first < 0) t_we_first = c;
        t_we_last = c;
        t_we++;
      end
      ack = (port == 0) ? p0_ack[g] : p1_ack[g];
      if (ack) begin
        t_lat = c;
        t_rd  = (port == 0) ? p0_rdata[g] : p1_rdata[g];
        t_own = owner[g];
      end
    end
    p0_req[g] = 1'b0;
    p1_req[g] = 1'b0;
  endtask

  task automatic run_basic(input int g, input int ac);
    preload(g, 19'h1234A, 8'h5A);
    txn(g, 0, 1'b0, 19'h1234A, 8'h00);
    chk($sformatf("rd_lat_g%0d", g), t_lat, ac + 2);
    chk($sformatf("rd_oe_cycles_g%0d", g), t_oe, ac + 1);
    chk($sformatf("rd_no_we_g%0d", g), t_we, 0);
    chk($sformatf("rd_data_g%0d", g), t_rd, 8'h5A);
    chk($sformatf("rd_owner_g%0d", g), t_own, 0);
    step(); step();
    chk($sformatf("rd_data_held_g%0d", g), p0_rdata[g], 8'h5A);
    txn(g, 1, 1'b1, 19'h7FFFF, 8'hC3);
    chk($sformatf("wr_lat_g%0d", g), t_lat, ac + 3);
    chk($sformatf("wr_we_cycles_g%0d", g), t_we, ac);
    chk($sformatf("wr_setup_g%0d", g), t_we_first - t_ce_first, 1);
    chk($sformatf("wr_hold_g%0d", g), t_ce_last - t_we_last, 1);
    chk($sformatf("wr_dqoe_cycles_g%0d", g), t_dqoe, ac + 2);
    chk($sformatf("wr_no_oe_g%0d", g), t_oe, 0);
    chk($sformatf("wr_owner_g%0d", g), t_own, 1);
    chk($sformatf("wr_model_g%0d", g), peek(mkey(g, 19'h7FFFF)), 8'hC3);
    txn(g, 0, 1'b0, 19'h7FFFF, 8'h00);
    chk($sformatf("rdback_g%0d", g), t_rd, 8'hC3);
  endtask

  int ord_port[$];
  int ord_cyc[$];
  int ord_own[$];

  // Both ports issue reads; keep_high models requesters that re-request at once.
  task automatic run_both(input int g, input int n, input bit keep_high, input int drop_p0_at);
    step();
    ord_port.delete(); ord_cyc.delete(); ord_own.delete();
    p0_we[g] = 1'b0; p0_addr[g] = 19'h00010;
    p1_we[g] = 1'b0; p1_addr[g] = 19'h00020;
    p0_req[g] = 1'b1; p1_req[g] = 1'b1;
    for (int c = 1; c <= n * 20 && ord_port.size() < n; c++) begin
      step();
      if (p0_ack[g] || p1_ack[g]) begin
        ord_port.push_back(p1_ack[g] ? 1 : 0);
        ord_cyc.push_back(c);
        ord_own.push_back(int'(owner[g]));
        if (!keep_high) begin
          if (p0_ack[g]) p0_req[g] = 1'b0;
          if (p1_ack[g]) p1_req[g] = 1'b0;
        end
        if (drop_p0_at > 0 && ord_port.size() == drop_p0_at) p0_req[g] = 1'b0;
      end
    end
    p0_req[g] = 1'b0;
    p1_req[g] = 1'b0;
  endtask

  initial begin
    logic [9:0] pat;
    int p1_wins;
    int acks;

    rst = '1;
    p0_req = '0; p1_req = '0; p0_we = '0; p1_we = '0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    repeat (3) step();
    for (int g = 0; g < N; g++) begin
      chk($sformatf("rst_strobes_g%0d", g), {ce[g], oe[g], we_n[g], dq_oe[g]}, 4'b1110);
      chk($sformatf("rst_misc_g%0d", g),
          {adr[g], dq_o[g], busy[g], owner[g], p0_ack[g], p1_ack[g]}, 0);
      chk($sformatf("rst_rdata_g%0d", g), {p0_rdata[g], p1_rdata[g]}, 0);
    end
    rst = '0;
    step();

    run_basic(0, 2);
    run_basic(2, 1);
    run_basic(3, 15);

    run_both(0, 2, 1'b0, 0);
    chk("simul_count", ord_port.size(), 2);
    if (ord_port.size() == 2) begin
      chk("simul_first_port", ord_port[0], 0);
      chk("simul_first_cyc", ord_cyc[0], 4);
      chk("simul_first_owner", ord_own[0], 0);
      chk("simul_second_port", ord_port[1], 1);
      chk("simul_second_cyc", ord_cyc[1], 9);
      chk("simul_second_owner", ord_own[1], 1);
    end

    run_both(0, 10, 1'b1, 0);
    pat = '0;
    for (int i = 0; i < ord_port.size() && i < 10; i++) pat[i] = ord_port[i][0];
    chk("streak_count", ord_port.size(), 10);
    chk("streak_order", pat, 10'b10000_10000);

    run_both(1, 21, 1'b1, 20);
    p1_wins = 0;
    for (int i = 0; i < ord_port.size() && i < 20; i++) p1_wins += ord_port[i];
    chk("strict_count", ord_port.size(), 21);
    chk("strict_no_p1", p1_wins, 0);
    if (ord_port.size() == 21) begin
      chk("strict_last_port", ord_port[20], 1);
      chk("strict_last_gap", ord_cyc[20] - ord_cyc[19], 5);
    end

    step();
    p1_we[0] = 1'b1; p1_addr[0] = 19'h00100; p1_wdata[0] = 8'h77; p1_req[0] = 1'b1;
    step();
    step();
    chk("rst_mid_we_active", we_n[0], 0);
    rst[0] = 1'b1;
    step();
    chk("rst_mid_strobes", {ce[0], oe[0], we_n[0], dq_oe[0]}, 4'b1110);
    chk("rst_mid_idle", {busy[0], p1_ack[0], adr[0]}, 0);
    rst[0] = 1'b0;
    p1_req[0] = 1'b0;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (p0_ack[0] || p1_ack[0] || busy[0]) acks++;
    end
    chk("rst_mid_no_ack", acks, 0);
    txn(0, 1, 1'b1, 19'h00100, 8'h77);
    chk("reissue_lat", t_lat, 5);
    txn(0, 0, 1'b0, 19'h00100, 8'h00);
    chk("reissue_rdback", t_rd, 8'h77);

    step();
    chk("no_contention", contention, 0);
    chk("ack_owner", bad_ack, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
